reward_engine: RTL and testbench

REWARD_ENGINE -- requirements
Module: reward_engine

---
 rtl/reward_engine_if.sv | 21 ++
 rtl/reward_engine.sv | 161 ++++++++++++++++
 tb/tb_reward_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reward_engine_if.sv
// Memory bus between reward_engine (master) and its table memory (slave).
// Read data is expected one cycle after the address is presented.
interface reward_engine_if #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  mem_we;

    modport master (
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/reward_engine.sv
// Reward engine: writes the cluster entry, reads the hop entry, then read-modify-writes the Q entry.
// Optional build macro REWARD_SAT_EN: saturate q + reward instead of wrapping.
module reward_engine #(
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned CLUSTER_BASE = 'h148,
    parameter int unsigned HOP_BASE     = 'h1C8,
    parameter int unsigned ACTION_BASE  = 'h48,
    parameter int unsigned STRIDE_LOG2  = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] reward,
    reward_engine_if.master       mem,
    output logic [WORD_WIDTH-1:0] hop_value,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned EW = ADDR_WIDTH + WORD_WIDTH;

    typedef enum logic [3:0] {
        IDLE, ARMED, WR_CLUSTER, RD_HOP, CAP_HOP, RD_Q, CAP_Q, WR_Q, DONE
    } state_t;

    state_t state, next_state;
    logic   accept;

    logic [WORD_WIDTH-1:0] besthop_q, action_q, reward_q;
    logic [EW-1:0]         cl_entry, hop_entry, act_entry;
    logic                  cl_ovf, hop_ovf, act_ovf;
    logic [WORD_WIDTH-1:0] q_d, q_sum;

    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WORD_WIDTH-1:0] wdata_d;
    logic                  we_d, ovf_d, busy_d, done_d;

    function automatic logic [EW-1:0] entry(input int unsigned base,
                                            input logic [WORD_WIDTH-1:0] idx);
        entry = EW'(base) + (EW'(idx) << STRIDE_LOG2);
    endfunction

    // Cluster write is issued on the accept edge, so its operands come straight from the ports.
    assign cl_entry  = entry(CLUSTER_BASE, MY_CLUSTER_ID);
    assign hop_entry = entry(HOP_BASE, besthop_q);
    assign act_entry = entry(ACTION_BASE, action_q);
    assign cl_ovf    = |cl_entry[EW-1:ADDR_WIDTH];
    assign hop_ovf   = |hop_entry[EW-1:ADDR_WIDTH];
    assign act_ovf   = |act_entry[EW-1:ADDR_WIDTH];

    assign q_d = act_ovf ? '0 : mem.mem_rdata;
`ifdef REWARD_SAT_EN
    logic [WORD_WIDTH:0] sum_full;
    assign sum_full = {1'b0, q_d} + {1'b0, reward_q};
    assign q_sum    = sum_full[WORD_WIDTH] ? '1 : sum_full[WORD_WIDTH-1:0];
`else
    assign q_sum = q_d + reward_q;
`endif

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE:       if (en) next_state = ARMED;
            ARMED: begin
                if (!en) next_state = IDLE;
                else if (start) begin
                    next_state = WR_CLUSTER;
                    accept     = 1'b1;
                end
            end
            WR_CLUSTER: next_state = RD_HOP;
            RD_HOP:     next_state = CAP_HOP;
            CAP_HOP:    next_state = RD_Q;
            RD_Q:       next_state = CAP_Q;
            CAP_Q:      next_state = WR_Q;
            WR_Q:       next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Bus outputs are registered against next_state so they line up with the state they belong to.
    always_comb begin
        addr_d  = mem.mem_addr;
        wdata_d = mem.mem_wdata;
        we_d    = 1'b0;
        ovf_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (next_state)
            WR_CLUSTER: begin
                addr_d  = cl_entry[ADDR_WIDTH-1:0];
                wdata_d = MY_NODE_ID;
                we_d    = ~cl_ovf;
                ovf_d   = cl_ovf;
                busy_d  = 1'b1;
            end
            RD_HOP: begin
                addr_d = hop_entry[ADDR_WIDTH-1:0];
                ovf_d  = hop_ovf;
                busy_d = 1'b1;
            end
            RD_Q: begin
                addr_d = act_entry[ADDR_WIDTH-1:0];
                ovf_d  = act_ovf;
                busy_d = 1'b1;
            end
            WR_Q: begin
                addr_d  = act_entry[ADDR_WIDTH-1:0];
                wdata_d = q_sum;
                we_d    = ~act_ovf;
                ovf_d   = act_ovf;
                busy_d  = 1'b1;
            end
            CAP_HOP, CAP_Q: busy_d = 1'b1;
            DONE:           done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_we    <= 1'b0;
            hop_value     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            besthop_q     <= '0;
            action_q      <= '0;
            reward_q      <= '0;
        end else begin
            mem.mem_addr  <= addr_d;
            mem.mem_wdata <= wdata_d;
            mem.mem_we    <= we_d;
            busy          <= busy_d;
            done          <= done_d;
            if (accept) begin
                besthop_q <= besthop;
                action_q  <= action;
                reward_q  <= reward;
                err       <= ovf_d;
            end else if (ovf_d) begin
                err <= 1'b1;
            end
            if (state == CAP_HOP) hop_value <= hop_ovf ? '0 : mem.mem_rdata;
        end
    end
endmodule

// File: tb/tb_reward_engine.sv
// Scoreboard bench for reward_engine: stimulus queues expected writes/done pulses,
// a negedge monitor pops and compares them; a small memory model serves the bus.
module tb_reward_engine;
    logic        clock = 1'b0;
    logic        rst = 1'b1, en = 1'b0, start = 1'b0;
    logic [15:0] MY_NODE_ID = '0, MY_CLUSTER_ID = '0, action = '0, besthop = '0, reward = '0;
    logic [15:0] hop_value;
    logic        busy, done, err;

    reward_engine_if #(.WORD_WIDTH(16), .ADDR_WIDTH(11)) bus();

    reward_engine #(.WORD_WIDTH(16), .ADDR_WIDTH(11)) dut (
        .clock(clock), .rst(rst), .en(en), .start(start),
        .MY_NODE_ID(MY_NODE_ID), .MY_CLUSTER_ID(MY_CLUSTER_ID),
        .action(action), .besthop(besthop), .reward(reward),
        .mem(bus), .hop_value(hop_value), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [15:0] mem_arr [2048];
    logic        tb_we = 1'b0;
    logic [10:0] tb_a = '0;
    logic [15:0] tb_d = '0;
    always @(posedge clock) begin
        bus.mem_rdata <= mem_arr[bus.mem_addr];
        if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
        else if (tb_we) mem_arr[tb_a] <= tb_d;
    end

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [15:0] a;   // write address, or expected hop_value at done
        logic [15:0] d;   // write data, or expected err at done
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!rst && (bus.mem_we === 1'b1 || done === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'({done, bus.mem_we}), 32'(0));
            end else begin
                e = sb.pop_front();
                check("evt_kind", 32'(done), 32'(e.is_done));
                check("evt_cycle", 32'(cyc), 32'(e.cyc));
                if (e.is_done) begin
                    check("done_hop", 32'(hop_value), 32'(e.a));
                    check("done_err", 32'(err), 32'(e.d));
                    check("done_busy", 32'(busy), 32'(0));
                end else begin
                    check("wr_addr", 32'(bus.mem_addr), 32'(e.a));
                    check("wr_data", 32'(bus.mem_wdata), 32'(e.d));
                end
            end
        end
    end

    task automatic preload(input logic [10:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        @(posedge clock); #1;
        tb_we = 1'b0;
    endtask

    task automatic run_seq(input logic [15:0] cl, node, hop, act, rew,
                           input bit cl_ok, input logic [10:0] cl_a,
                           input bit hop_ok, input logic [10:0] hop_a, input logic [15:0] hop_v,
                           input bit q_ok, input logic [10:0] q_a, input logic [15:0] q_w,
                           input bit e_err);
        int k;
        en = 1'b1;
        @(posedge clock); #1;
        MY_CLUSTER_ID = cl; MY_NODE_ID = node; besthop = hop; action = act; reward = rew;
        start = 1'b1;
        k = cyc;
        if (cl_ok) sb.push_back('{1'b0, k + 1, 16'(cl_a), node});
        if (q_ok)  sb.push_back('{1'b0, k + 6, 16'(q_a), q_w});
        sb.push_back('{1'b1, k + 7, hop_v, 16'(e_err)});
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock); #1;
            if (i == 1) begin
                start = 1'b0;
                MY_CLUSTER_ID = ~cl; MY_NODE_ID = ~node; besthop = ~hop; action = ~act; reward = ~rew;
            end
            if (i == 2) begin
                check("busy_mid", 32'(busy), 32'(1));
                check("rdhop_we", 32'(bus.mem_we), 32'(0));
                if (hop_ok) check("rdhop_addr", 32'(bus.mem_addr), 32'(hop_a));
            end
            if (i == 3) start = 1'b1;
            if (i == 4) begin
                start = 1'b0;
                check("hop_value_k4", 32'(hop_value), 32'(hop_v));
            end
        end
        check("sb_drained", 32'(sb.size()), 32'(0));
        sb.delete();
        en = 1'b0;
    endtask

    initial begin
        logic [15:0] sat_exp;
        int k;
`ifdef REWARD_SAT_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'h0010;
`endif
        for (int i = 0; i < 2048; i++) mem_arr[i] = 16'h0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_addr", 32'(bus.mem_addr), 32'(0));
        check("rst_wdata", 32'(bus.mem_wdata), 32'(0));
        check("rst_we", 32'(bus.mem_we), 32'(0));
        check("rst_hop", 32'(hop_value), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        rst = 1'b0;

        preload(11'h1CC, 16'h0055);
        preload(11'h04A, 16'h0010);
        preload(11'h04C, 16'h0100);
        preload(11'h1C6, 16'h7777);
        preload(11'h1C8, 16'hABCD);
        preload(11'h1CA, 16'h0042);
        preload(11'h048, 16'h0003);
        preload(11'h7FE, 16'h0002);

        run_seq(16'd3, 16'd7, 16'd2, 16'd1, 16'h0005, 1'b1, 11'h14E,
                1'b1, 11'h1CC, 16'h0055, 1'b1, 11'h04A, 16'h0015, 1'b0);
        run_seq(16'd1, 16'd9, 16'hFFFF, 16'd2, 16'h0001, 1'b1, 11'h14A,
                1'b0, 11'h000, 16'h0000, 1'b1, 11'h04C, 16'h0101, 1'b1);
        preload(11'h04A, 16'hFFF0);
        run_seq(16'd0, 16'h1234, 16'd0, 16'd1, 16'h0020, 1'b1, 11'h148,
                1'b1, 11'h1C8, 16'hABCD, 1'b1, 11'h04A, sat_exp, 1'b0);
        run_seq(16'hFFFF, 16'hBEEF, 16'd1, 16'd0, 16'h0004, 1'b0, 11'h000,
                1'b1, 11'h1CA, 16'h0042, 1'b1, 11'h048, 16'h0007, 1'b1);
        run_seq(16'd2, 16'd5, 16'd1, 16'hFFFF, 16'h0009, 1'b1, 11'h14C,
                1'b1, 11'h1CA, 16'h0042, 1'b0, 11'h000, 16'h0000, 1'b1);
        run_seq(16'd4, 16'd6, 16'd1, 16'h03DB, 16'h0003, 1'b1, 11'h150,
                1'b1, 11'h1CA, 16'h0042, 1'b1, 11'h7FE, 16'h0005, 1'b0);

        // Abort: reset in the middle of a sequence must squash every later write and done.
        preload(11'h1CC, 16'h0055);
        en = 1'b1;
        @(posedge clock); #1;
        MY_CLUSTER_ID = 16'hFFFF; MY_NODE_ID = 16'd7; besthop = 16'd2; action = 16'd1; reward = 16'd5;
        start = 1'b1;
        k = cyc;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock); #1;
            if (i == 1) start = 1'b0;
            if (i == 2) check("abort_err_set", 32'(err), 32'(1));
            if (i == 3) begin
                rst = 1'b1; en = 1'b1; start = 1'b1;
            end
            if (i == 4) begin
                check("abort_cycle", 32'(cyc), 32'(k + 4));
                check("abort_addr", 32'(bus.mem_addr), 32'(0));
                check("abort_wdata", 32'(bus.mem_wdata), 32'(0));
                check("abort_we", 32'(bus.mem_we), 32'(0));
                check("abort_hop", 32'(hop_value), 32'(0));
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                check("abort_err", 32'(err), 32'(0));
                rst = 1'b0; en = 1'b0; start = 1'b0;
            end
        end
        check("abort_sb", 32'(sb.size()), 32'(0));

        // Disarm while armed: start arriving with en low is ignored.
        en = 1'b1;
        @(posedge clock); #1;
        en = 1'b0; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock); #1;
            check("disarm_busy", 32'(busy), 32'(0));
        end
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
